// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: debounced step pulses with wrapping counter; auto-run mode built only with AUTORUN_EN defined
module step_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int RATE_DIV = 25,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic step_btn_i,
  input  logic run_btn_i,
  output logic step_o,
  output logic run_o,
  output logic [CNT_W-1:0] step_count_o
);
`ifdef AUTORUN_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(RATE_DIV);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [VW-1:0] DIV_LAST = VW'(RATE_DIV - 1);
  typedef enum logic {MANUAL, RUN} state_t;
  state_t state, state_nxt;
  logic [NB-1:0] btn, s1, s2, deb, deb_q, rise;
  logic [DW-1:0] dcnt [NB];
  logic [VW-1:0] div, div_nxt;
  logic step_rise, run_rise, step_nxt;
`ifdef AUTORUN_EN
  assign btn = {run_btn_i, step_btn_i};
  assign run_rise = rise[NB-1];
`else
  logic unused_run;
  assign unused_run = run_btn_i;
  assign btn = step_btn_i;
  assign run_rise = 1'b0;
`endif
  assign rise = deb & ~deb_q;
  assign step_rise = rise[0];
  // bit 0 is the step button, bit 1 (when built) the run button
  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_q <= '0;
      for (int i = 0; i < NB; i++) dcnt[i] <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      deb_q <= deb;
      for (int i = 0; i < NB; i++) begin
        dcnt[i] <= (s2[i] != deb[i] && dcnt[i] != DEB_LAST) ? dcnt[i] + 1'b1 : '0;
        deb[i] <= deb[i] ^ (s2[i] != deb[i] && dcnt[i] == DEB_LAST);
      end
    end
  end
  // a run rise always takes priority over stepping in either state
  always_comb begin
    state_nxt = state;
    div_nxt = '0;
    step_nxt = 1'b0;
    if (run_rise) begin
      state_nxt = (state == RUN) ? MANUAL : RUN;
    end else if (state == RUN) begin
      step_nxt = (div == DIV_LAST);
      div_nxt = step_nxt ? '0 : div + 1'b1;
    end else begin
      step_nxt = step_rise;
    end
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= MANUAL;
      div <= '0;
      step_o <= 1'b0;
      run_o <= 1'b0;
      step_count_o <= '0;
    end else begin
      state <= state_nxt;
      div <= div_nxt;
      step_o <= step_nxt;
      run_o <= (state_nxt == RUN);
      step_count_o <= step_count_o + CNT_W'(step_nxt);
    end
  end
endmodule

// File: tb/tb_step_clock_ctrl.sv
// tb_step_clock_ctrl: directed checks of debounce latency, bounce rejection, run mode, reset and counter wrap
module tb_step_clock_ctrl;
  logic clk = 0, nrst = 0, step_btn = 0, run_btn = 0, step_w = 0, prev = 0;
  logic step_o, run_o, step_w_o, run_w_o;
  logic [15:0] cnt;
  logic [1:0] cnt_w;
  int n_chk = 0, n_fail = 0, pulses = 0, dbl = 0;
  always #5 clk = ~clk;
  step_clock_ctrl #(.DEBOUNCE_CYCLES(5), .RATE_DIV(25), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .step_btn_i(step_btn), .run_btn_i(run_btn),
    .step_o(step_o), .run_o(run_o), .step_count_o(cnt)
  );
  step_clock_ctrl #(.DEBOUNCE_CYCLES(5), .RATE_DIV(25), .CNT_W(2)) dut_w (
    .clk(clk), .nrst(nrst), .step_btn_i(step_w), .run_btn_i(1'b0),
    .step_o(step_w_o), .run_o(run_w_o), .step_count_o(cnt_w)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (step_o) begin
        pulses++;
        if (prev) dbl++;
      end
      prev = step_o;
    end
  endtask
  task automatic reset_dut();
    nrst = 0;
    tick(2);
    nrst = 1;
    pulses = 0;
  endtask
  task automatic press_w();
    step_w = 1;
    tick(10);
    step_w = 0;
    tick(10);
  endtask
  initial begin
    tick(2);
    chk("rst_step", step_o, 0);
    chk("rst_run", run_o, 0);
    chk("rst_count", cnt, 0);
    nrst = 1;
    pulses = 0;
    step_btn = 1;
    tick(7);
    chk("step_early", step_o, 0);
    tick(1);
    chk("step_pulse", step_o, 1);
    chk("count_one", cnt, 1);
    tick(1);
    chk("step_single", step_o, 0);
    pulses = 0;
    tick(100);
    chk("hold_no_repeat", pulses, 0);
    step_btn = 0;
    tick(10);
    pulses = 0;
    step_btn = 1;
    tick(1);
    step_btn = 0;
    tick(12);
    chk("glitch", pulses, 0);
    chk("glitch_count", cnt, 1);
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      tick(2);
    end
    tick(15);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_count", cnt, 0);
`ifdef AUTORUN_EN
    reset_dut();
    run_btn = 1;
    tick(8);
    chk("run_on", run_o, 1);
    chk("run_no_step", step_o, 0);
    run_btn = 0;
    tick(24);
    chk("auto_not_yet", step_o, 0);
    tick(1);
    chk("auto_first", step_o, 1);
    pulses = 0;
    step_btn = 1;
    tick(20);
    step_btn = 0;
    tick(55);
    chk("auto_pulses", pulses, 3);
    chk("auto_count", cnt, 4);
    chk("run_still_on", run_o, 1);
    run_btn = 1;
    tick(8);
    chk("run_off", run_o, 0);
    run_btn = 0;
    pulses = 0;
    tick(60);
    chk("stopped_pulses", pulses, 0);
    reset_dut();
    run_btn = 1;
    tick(8);
    run_btn = 0;
    tick(75);
    chk("pre_reset_count", cnt, 3);
    nrst = 0;
    tick(1);
    nrst = 1;
    chk("rst_run_mode", run_o, 0);
    chk("rst_run_count", cnt, 0);
    chk("rst_run_step", step_o, 0);
    pulses = 0;
    tick(60);
    chk("post_reset_pulses", pulses, 0);
    reset_dut();
    run_btn = 1;
    step_btn = 1;
    tick(8);
    chk("simul_run", run_o, 1);
    chk("simul_no_step", pulses, 0);
    chk("simul_count", cnt, 0);
    run_btn = 0;
    step_btn = 0;
    tick(24);
    chk("simul_not_yet", step_o, 0);
    tick(1);
    chk("simul_first", step_o, 1);
    chk("simul_count1", cnt, 1);
`else
    reset_dut();
    run_btn = 1;
    tick(10);
    run_btn = 0;
    tick(30);
    chk("norun_mode", run_o, 0);
    chk("norun_pulses", pulses, 0);
`endif
    reset_dut();
    press_w();
    press_w();
    press_w();
    chk("wrap_pre", cnt_w, 3);
    chk("wrap_run", run_w_o, 0);
    press_w();
    chk("wrap_zero", cnt_w, 0);
    chk("no_back_to_back", dbl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
